// File: rtl/edge_pkg.sv
// ---------------------------------------------------------------------------
// edge_pkg
// Shared constants and types for the grayscale-to-edge-bitmap writer.
//   IMG_W / IMG_H : frame geometry (64x48); IMG_W is also the bitmap word width
//   AW            : bitmap read-address width seen by the VGA stage
//   PW            : grayscale pixel width
// ---------------------------------------------------------------------------
package edge_pkg;

    localparam int IMG_W = 64;
    localparam int IMG_H = 48;
    localparam int AW    = 7;
    localparam int PW    = 8;

    // Index widths for column (0..63) and row (0..47) counters.
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef logic [IMG_W-1:0] row_t;
    typedef logic [PW-1:0]    pix_t;
    typedef logic [CW-1:0]    col_t;
    typedef logic [RW-1:0]    rowidx_t;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        RUN
    } state_t;

    localparam col_t    LAST_COL = col_t'(IMG_W - 1);
    localparam rowidx_t LAST_ROW = rowidx_t'(IMG_H - 1);

    function automatic pix_t abs_diff(input pix_t a, input pix_t b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/edge_frame_writer_if.sv
// ---------------------------------------------------------------------------
// edge_frame_writer_if
// Raster pixel stream into the edge writer.
//   s_valid : source has a pixel
//   s_ready : sink can accept a pixel (transfer on s_valid && s_ready)
//   s_data  : grayscale pixel value
//   s_sof   : marks pixel (0,0) of a frame, qualified with s_valid
// ---------------------------------------------------------------------------
interface edge_frame_writer_if;
    import edge_pkg::*;

    logic s_valid;
    logic s_ready;
    pix_t s_data;
    logic s_sof;

    modport master (output s_valid, output s_data, output s_sof, input  s_ready);
    modport slave  (input  s_valid, input  s_data, input  s_sof, output s_ready);

endinterface

// File: rtl/edge_bitmap_ram.sv
// ---------------------------------------------------------------------------
// edge_bitmap_ram
// 48 x 64-bit edge bitmap, one word per row, bit c = column c.
//   clk     : write clock
//   wr_en   : synchronous write enable
//   wr_addr : row written
//   wr_data : row word written
//   rd_addr : row read by the VGA stage (asynchronous)
//   rd_data : row word; 0 for rd_addr >= 48; old contents on a same-cycle write
// ---------------------------------------------------------------------------
module edge_bitmap_ram
    import edge_pkg::*;
(
    input  logic          clk,
    input  logic          wr_en,
    input  rowidx_t       wr_addr,
    input  row_t          wr_data,
    input  logic [AW-1:0] rd_addr,
    output row_t          rd_data
);

    row_t mem [0:IMG_H-1];

    // NOTE: no reset on the array so it maps onto plain RAM; the writer's
    // CLEAR state zeroes it instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (rd_addr < AW'(IMG_H)) ? mem[rd_addr[RW-1:0]] : '0;

endmodule

// File: rtl/edge_frame_writer.sv
// ---------------------------------------------------------------------------
// edge_frame_writer
// Turns a 64x48 grayscale raster stream into a 1-bit gradient edge map
// (|p-left| + |p-up| > thresh) and stores one 64-bit word per row.
//   clk, rst   : clock, asynchronous active-high reset
//   s          : pixel stream (slave side)
//   thresh     : edge threshold, latched on an accepted s_sof
//   rd_addr    : bitmap row address from the VGA stage
//   rd_data    : bitmap row, combinational from rd_addr
//   frame_done : one-cycle pulse in the cycle row 47 is written
//   sync_err   : one-cycle pulse after an s_sof accepted mid-frame
// ---------------------------------------------------------------------------
module edge_frame_writer
    import edge_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    edge_frame_writer_if.slave s,
    input  pix_t               thresh,
    input  logic [AW-1:0]      rd_addr,
    output row_t               rd_data,
    output logic               frame_done,
    output logic               sync_err
);

    state_t  state, state_next;
    rowidx_t clr_addr;
    col_t    col;
    rowidx_t row;
    pix_t    thresh_q;
    pix_t    left_q;
    pix_t    line_buf [0:IMG_W-1];
    row_t    row_reg;
    logic    wr_en_q;
    rowidx_t wr_addr_q;
    row_t    wr_data_q;

    logic    accept, start, take_pix, row_end, frame_end;
    col_t    eff_c;
    rowidx_t eff_r;
    pix_t    up_pix, thr_eff;
    logic [PW:0] dx, dy, grad;
    logic    edge_bit;
    row_t    row_word;

    logic    ram_we;
    rowidx_t ram_wa;
    row_t    ram_wd;

    // s_ready is a pure function of state, so decode the transfer from state
    // directly instead of feeding s_ready back into logic.
    assign accept   = s.s_valid && (state != CLEAR);
    assign start    = accept && s.s_sof;
    // In IDLE only a start-of-frame pixel is processed; strays are dropped.
    assign take_pix = accept && (s.s_sof || state == RUN);

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        s.s_ready  = 1'b0;
        case (state)
            CLEAR: if (clr_addr == LAST_ROW) state_next = IDLE;
            IDLE: begin
                s.s_ready = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                s.s_ready = 1'b1;
                if (frame_end) state_next = IDLE;
            end
            default: state_next = CLEAR;
        endcase
    end

    // A start-of-frame pixel is always (0,0), wherever the counters were.
    always_comb begin
        eff_c    = start ? '0 : col;
        eff_r    = start ? '0 : row;
        up_pix   = line_buf[eff_c];
        dx       = (eff_c == '0) ? '0 : {1'b0, abs_diff(s.s_data, left_q)};
        dy       = (eff_r == '0) ? '0 : {1'b0, abs_diff(s.s_data, up_pix)};
        grad     = dx + dy;
        thr_eff  = start ? thresh : thresh_q;
        edge_bit = grad > {1'b0, thr_eff};
        row_word = row_reg;
        row_word[IMG_W-1] = edge_bit;
    end

    assign row_end   = take_pix && (eff_c == LAST_COL);
    assign frame_end = row_end && (eff_r == LAST_ROW);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr   <= '0;
            col        <= '0;
            row        <= '0;
            thresh_q   <= '0;
            left_q     <= '0;
            row_reg    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            wr_en_q    <= row_end;
            frame_done <= frame_end;
            // Any s_sof seen in RUN is out of place: the fresh-frame (0,0)
            // pixel is always taken in IDLE.
            sync_err   <= start && (state == RUN);

            if (state == CLEAR) clr_addr <= clr_addr + rowidx_t'(1);
            if (start)          thresh_q <= thresh;

            if (take_pix) begin
                left_q         <= s.s_data;
                row_reg[eff_c] <= edge_bit;
                if (row_end) begin
                    wr_addr_q <= eff_r;
                    wr_data_q <= row_word;
                end
                if (frame_end) begin
                    col <= '0;
                    row <= '0;
                end else if (row_end) begin
                    col <= '0;
                    row <= eff_r + rowidx_t'(1);
                end else begin
                    col <= eff_c + col_t'(1);
                    row <= eff_r;
                end
            end
        end
    end

    // Old line-buffer entry is read combinationally above, so the write here
    // gives read-before-write for free.
    always_ff @(posedge clk) begin
        if (take_pix) line_buf[eff_c] <= s.s_data;
    end

    // CLEAR owns the write port; pixel traffic cannot overlap it.
    assign ram_we = (state == CLEAR) || wr_en_q;
    assign ram_wa = (state == CLEAR) ? clr_addr : wr_addr_q;
    assign ram_wd = (state == CLEAR) ? '0 : wr_data_q;

    edge_bitmap_ram u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_wa),
        .wr_data (ram_wd),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_edge_frame_writer.sv
module tb_edge_frame_writer;
    import edge_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    pix_t        thresh = '0;
    logic [AW-1:0] rd_addr = '0;
    row_t        rd_data;
    logic        frame_done, sync_err;

    edge_frame_writer_if sif ();

    edge_frame_writer dut (
        .clk        (clk),
        .rst        (rst),
        .s          (sif),
        .thresh     (thresh),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   fd_cnt = 0;
    int   se_cnt = 0;
    row_t last47 = '0;
    row_t exp_q [$];
    logic [7:0] img [0:IMG_H-1][0:IMG_W-1];

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (sync_err === 1'b1)   se_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference edge row computed from the whole stored image.
    function automatic row_t model_row(input int r, input int thr);
        row_t res = '0;
        for (int c = 0; c < IMG_W; c++) begin
            int g = 0;
            if (c > 0) g += iabs(int'(img[r][c]) - int'(img[r][c-1]));
            if (r > 0) g += iabs(int'(img[r][c]) - int'(img[r-1][c]));
            res[c] = (g > thr);
        end
        return res;
    endfunction

    task automatic push_frame(input int thr);
        for (int r = 0; r < IMG_H; r++) exp_q.push_back(model_row(r, thr));
    endtask

    task automatic send_frame(input pix_t thr, input int n_pix, input int gap_max,
                              input bit mid_check, input row_t exp_row0);
        thresh = thr;
        for (int i = 0; i < n_pix; i++) begin
            int r;
            int c;
            r = i / IMG_W;
            c = i % IMG_W;
            repeat ($urandom_range(gap_max, 0)) begin
                @(negedge clk);
                sif.s_valid = 1'b0;
                sif.s_sof   = 1'b0;
            end
            @(negedge clk);
            sif.s_valid = 1'b1;
            sif.s_data  = img[r][c];
            sif.s_sof   = (i == 0);
            if (mid_check && i == 0) begin
                @(negedge clk);
                sif.s_valid = 1'b0;
                sif.s_sof   = 1'b0;
                check("sync_err_pulse", 64'(sync_err), 64'd1);
                rd_addr = 7'd0;
                #1 check("kept_row0", rd_data, exp_row0);
                rd_addr = 7'd3;
                #1 check("no_partial_write_row3", rd_data, 64'd0);
            end
        end
    endtask

    task automatic check_frame(input string tag, input int fd_base);
        int   waited;
        row_t exp;
        @(negedge clk);
        sif.s_valid = 1'b0;
        sif.s_sof   = 1'b0;
        waited = 1;
        while (frame_done !== 1'b1 && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_done_latency"}, 64'(waited), 64'd1);
        rd_addr = 7'd47;
        #1 check({tag, "_rd_old_during_write"}, rd_data, last47);
        @(negedge clk);
        for (int r = 0; r < IMG_H; r++) begin
            rd_addr = 7'(r);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s_row%0d: observed=%h expected=<scoreboard empty>", tag, r, rd_data);
            end else begin
                exp = exp_q.pop_front();
                check($sformatf("%s_row%0d", tag, r), rd_data, exp);
                if (r == IMG_H - 1) last47 = exp;
            end
        end
        check({tag, "_done_pulses"}, 64'(fd_cnt - fd_base), 64'd1);
    endtask

    task automatic fill(input logic [7:0] a, input logic [7:0] b, input int mode, input int split);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                case (mode)
                    0: img[r][c] = (c < split) ? a : b;
                    1: img[r][c] = (r < split) ? a : b;
                    default: img[r][c] = ((r + c) % 2 == 1) ? b : a;
                endcase
    endtask

    initial begin
        int   n;
        int   base;
        row_t row0_abort;

        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_sof   = 1'b0;

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(sif.s_ready), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_sync_err", 64'(sync_err), 64'd0);
        rst = 1'b0;

        // s_ready stays low for exactly the 48 clear cycles.
        #1;
        n = 0;
        while (sif.s_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("clear_cycles", 64'(n), 64'd48);

        for (int a = 0; a < IMG_H; a++) begin
            rd_addr = 7'(a);
            #1 check($sformatf("cleared_row%0d", a), rd_data, 64'd0);
        end
        rd_addr = 7'd100;
        #1 check("out_of_range_read", rd_data, 64'd0);

        // Flat frame.
        fill(8'h80, 8'h80, 0, 0);
        base = fd_cnt;
        push_frame(10);
        send_frame(8'd10, IMG_W * IMG_H, 0, 1'b0, '0);
        check_frame("flat", base);

        // Stray non-sof pixels in IDLE must be discarded.
        @(negedge clk);
        check("ready_idle", 64'(sif.s_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sif.s_valid = 1'b1;
            sif.s_data  = 8'hFF;
            sif.s_sof   = 1'b0;
        end

        // Vertical step: only bit 32 of every row.
        fill(8'h00, 8'hFF, 0, 32);
        base = fd_cnt;
        push_frame(100);
        send_frame(8'd100, IMG_W * IMG_H, 0, 1'b0, '0);
        check_frame("vstep", base);

        // Horizontal step: row 24 all ones.
        fill(8'h10, 8'hF0, 1, 24);
        base = fd_cnt;
        push_frame(50);
        send_frame(8'd50, IMG_W * IMG_H, 0, 1'b0, '0);
        check_frame("hstep", base);

        // Single 0x40 pixel at (5,5): grad 64 at (6,5)/(5,6) sits on the
        // thresh=64 boundary, 128 at (5,5).
        fill(8'h00, 8'h00, 0, 0);
        img[5][5] = 8'h40;
        base = fd_cnt;
        push_frame(64);
        send_frame(8'd64, IMG_W * IMG_H, 0, 1'b0, '0);
        check_frame("thr64", base);
        base = fd_cnt;
        push_frame(63);
        send_frame(8'd63, IMG_W * IMG_H, 0, 1'b0, '0);
        check_frame("thr63", base);
        check("no_sync_err_normal", 64'(se_cnt), 64'd0);

        // Mid-frame sof at (10,3) with random gaps, then a full checkerboard
        // frame at thresh=255 (interior grad 510 must still pass).
        fill(8'h00, 8'hFF, 2, 0);
        row0_abort = model_row(0, 100);
        base = fd_cnt;
        n = se_cnt;
        send_frame(8'd100, 3 * IMG_W + 10, 2, 1'b0, '0);
        push_frame(255);
        send_frame(8'd255, IMG_W * IMG_H, 2, 1'b1, row0_abort);
        check_frame("restart", base);
        check("sync_err_pulses", 64'(se_cnt - n), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
